// File: rtl/f_event_pkg.sv
// f_event_pkg: shared widths, FIFO depth and FSM state type for the event monitor
package f_event_pkg;
    localparam int CNT_W = 8;
    localparam int S_W = 3;
    localparam int FIFO_DEPTH = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    typedef enum logic {IDLE, TRACK} state_t;
endpackage

// File: rtl/evt_fifo.sv
// evt_fifo: small first-word-fall-through FIFO; push while full is accepted only alongside a pop
module evt_fifo #(
    parameter int W = 3,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PTR_W:0] wp, rp;
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = empty ? '0 : mem[rp[PTR_W-1:0]];
    // storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[PTR_W-1:0]] <= din;
    end
    // pointers carry an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/f_event_monitor.sv
// f_event_monitor: passive observer of F rising edges (count, captured S, gap); optional capture FIFO under EVT_FIFO_EN
module f_event_monitor
    import f_event_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    input  logic           F,
    input  logic [S_W-1:0] S,
    input  logic           CLR,
    input  logic           RD,
    output logic           EVT,
    output logic [CNT_W-1:0] COUNT,
    output logic [S_W-1:0] LAST_S,
    output logic [CNT_W-1:0] GAP,
    output logic           OVF,
    output logic [S_W-1:0] DOUT,
    output logic           EMPTY,
    output logic           FULL
);
    state_t st;
    logic f_q, ev;
    logic [CNT_W-1:0] gap_cnt;
    assign ev = F & ~f_q;
    // edge history; only RESET clears it so CLR cannot fabricate an edge
    always_ff @(posedge CLK) begin
        if (RESET) f_q <= 1'b0;
        else f_q <= F;
    end
    // statistics and IDLE/TRACK tracking; CLR discards a coincident event
    always_ff @(posedge CLK) begin
        if (RESET || CLR) begin
            st <= IDLE;
            EVT <= 1'b0;
            COUNT <= '0;
            LAST_S <= '0;
            GAP <= '0;
            OVF <= 1'b0;
            gap_cnt <= '0;
        end else begin
            EVT <= ev;
            if (ev) begin
                COUNT <= (COUNT == CNT_MAX) ? COUNT : COUNT + 1'b1;
                OVF <= OVF | (COUNT == CNT_MAX);
                LAST_S <= S;
                st <= TRACK;
                gap_cnt <= CNT_W'(1);
                if (st == TRACK) GAP <= gap_cnt;
            end else if (st == TRACK && gap_cnt != CNT_MAX) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end
`ifdef EVT_FIFO_EN
    evt_fifo #(.W(S_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(CLK),
        .rst(RESET | CLR),
        .push(ev),
        .din(S),
        .pop(RD),
        .dout(DOUT),
        .empty(EMPTY),
        .full(FULL)
    );
`else
    logic unused_rd;
    assign unused_rd = RD;
    assign DOUT = '0;
    assign EMPTY = 1'b1;
    assign FULL = 1'b0;
`endif
endmodule

// File: tb/tb_f_event_monitor.sv
// tb_f_event_monitor: directed scenarios plus random stimulus against an event-history reference model
module tb_f_event_monitor;
    logic CLK = 1'b0;
    logic RESET, F, CLR, RD;
    logic [2:0] S;
    logic EVT, OVF, EMPTY, FULL;
    logic [7:0] COUNT, GAP;
    logic [2:0] LAST_S, DOUT;

    f_event_monitor dut (
        .CLK(CLK), .RESET(RESET), .F(F), .S(S), .CLR(CLR), .RD(RD),
        .EVT(EVT), .COUNT(COUNT), .LAST_S(LAST_S), .GAP(GAP), .OVF(OVF),
        .DOUT(DOUT), .EMPTY(EMPTY), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: event times and a queue, not registers
    logic m_fq = 1'b0;
    logic m_evt = 1'b0;
    int m_cnt = 0;
    int m_last = 0;
    int m_gap = 0;
    logic m_ovf = 1'b0;
    logic m_seen = 1'b0;
    int m_t_last = 0;
    int t = 0;
    int q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic clr, input logic f, input logic [2:0] s, input logic rd);
        logic ev, pop;
        int sz;
        RESET = rst; CLR = clr; F = f; S = s; RD = rd;
        @(posedge CLK);
        t++;
        ev = f & ~m_fq;
        if (rst) begin
            m_fq = 1'b0; m_evt = 1'b0; m_cnt = 0; m_last = 0; m_gap = 0;
            m_ovf = 1'b0; m_seen = 1'b0; q.delete();
        end else begin
            m_fq = f;
            if (clr) begin
                m_evt = 1'b0; m_cnt = 0; m_last = 0; m_gap = 0;
                m_ovf = 1'b0; m_seen = 1'b0; q.delete();
            end else begin
                m_evt = ev;
                if (ev) begin
                    if (m_cnt == 255) m_ovf = 1'b1;
                    else m_cnt++;
                    m_last = s;
                    if (m_seen) m_gap = (t - m_t_last > 255) ? 255 : t - m_t_last;
                    m_seen = 1'b1;
                    m_t_last = t;
                end
`ifdef EVT_FIFO_EN
                sz = q.size();
                pop = rd && sz > 0;
                if (pop) void'(q.pop_front());
                if (ev && (sz < 4 || pop)) q.push_back(s);
`endif
            end
        end
        #1;
        check_eq("evt", EVT, m_evt);
        check_eq("count", COUNT, m_cnt);
        check_eq("last_s", LAST_S, m_last);
        check_eq("gap", GAP, m_gap);
        check_eq("ovf", OVF, m_ovf);
`ifdef EVT_FIFO_EN
        check_eq("dout", DOUT, q.size() > 0 ? q[0] : 0);
        check_eq("empty", EMPTY, q.size() == 0);
        check_eq("full", FULL, q.size() == 4);
`else
        check_eq("dout", DOUT, 0);
        check_eq("empty", EMPTY, 1);
        check_eq("full", FULL, 0);
`endif
    endtask

    initial begin
        int evts;
        RESET = 1'b1; CLR = 1'b0; F = 1'b0; S = '0; RD = 1'b0;
        #2;
        // reset, then a 2-cycle F pulse with S=3
        step(1, 0, 0, 0, 0);
        check_eq("rst_empty", EMPTY, 1);
        check_eq("rst_count", COUNT, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 3'b011, 0);
        check_eq("s1_evt", EVT, 1);
        step(0, 0, 1, 3'b011, 0);
        check_eq("s1_evt_once", EVT, 0);
        check_eq("s1_count", COUNT, 1);
        check_eq("s1_last", LAST_S, 3);
        check_eq("s1_gap", GAP, 0);
        step(0, 0, 0, 0, 0);
        // two edges 10 cycles apart
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 5, 0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 0);
        check_eq("s2_gap", GAP, 10);
        check_eq("s2_count", COUNT, 2);
        // 256 events saturate and set OVF, CLR returns to IDLE
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 1, 3'(i), 0);
            step(0, 0, 0, 0, 0);
        end
        check_eq("s3_count", COUNT, 255);
        check_eq("s3_ovf", OVF, 1);
        step(0, 1, 0, 0, 0);
        check_eq("s3_clr_count", COUNT, 0);
        check_eq("s3_clr_ovf", OVF, 0);
        step(0, 0, 1, 2, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0);
        check_eq("s3_gap_after_idle", GAP, 6);
        // F held high for 20 cycles
        step(0, 1, 0, 0, 0);
        evts = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 1, 0);
            evts += EVT;
        end
        check_eq("s4_one_evt", evts, 1);
        step(0, 0, 0, 0, 0);
`ifdef EVT_FIFO_EN
        // five events fill the FIFO, four pops drain it in order
        step(0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1, 3'(i), 0);
            step(0, 0, 0, 0, 0);
        end
        check_eq("s5_full", FULL, 1);
        for (int i = 1; i <= 4; i++) begin
            check_eq("s5_dout", DOUT, i);
            step(0, 0, 0, 0, 1);
        end
        check_eq("s5_empty", EMPTY, 1);
`endif
        // reset coincident with an edge, then F still high after reset
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 4, 0);
        check_eq("s6_evt", EVT, 0);
        check_eq("s6_count", COUNT, 0);
        step(0, 0, 1, 4, 0);
        check_eq("s6_post_evt", EVT, 1);
        // random soak
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 2) != 0, 3'($urandom), 1'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/f_event_monitor.md
F_EVENT_MONITOR -- requirements
Module: f_event_monitor

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port F, input, 1 bit: detector output from the upstream sequence machine.
REQ-004 SHALL have port S, input, 3 bits: state vector of the upstream machine.
REQ-005 SHALL have port CLR, input, 1 bit: synchronous clear of statistics, active-high.
REQ-006 SHALL have port EVT, output, 1 bit: one-cycle pulse per detected F rising edge.
REQ-007 SHALL have port COUNT, output, 8 bits: number of events since reset or clear.
REQ-008 SHALL have port LAST_S, output, 3 bits: value of S captured at the most recent event.
REQ-009 SHALL have port GAP, output, 8 bits: clock cycles between the last two events, saturating.
REQ-010 SHALL have port OVF, output, 1 bit: sticky flag, set when COUNT would pass 255.
REQ-011 SHALL have ports RD (input, 1), DOUT (output, 3), EMPTY (output, 1) and FULL (output, 1) for the capture FIFO.

Function
REQ-012 SHALL register F into f_q every cycle; an event is the cycle in which F=1 and f_q=0.
REQ-013 SHALL assert EVT for exactly one cycle, in the cycle after the event edge (latency 1); F held high yields one EVT only.
REQ-014 SHALL, on each event, increment COUNT and load LAST_S with S sampled at the event edge.
REQ-015 SHALL saturate COUNT at 255; an event arriving at 255 sets OVF, and OVF stays set until RESET or CLR.
REQ-016 SHALL implement an FSM with states IDLE (no event seen yet) and TRACK (at least one event seen): IDLE->TRACK on the first event; TRACK->TRACK on every later event; any state->IDLE on RESET or CLR.
REQ-017 SHALL, in TRACK, increment gap_cnt every cycle, saturating at 255, and reset gap_cnt to 1 on each event.
REQ-018 SHALL, on an event in TRACK, load GAP with gap_cnt; the first event (taken from IDLE) leaves GAP unchanged.
REQ-019 SHALL give CLR priority over a simultaneous event: the event is discarded and f_q still updates.
REQ-020 SHALL not alter F, S or any upstream behaviour; the block is a pure observer.

Reset
REQ-021 SHALL, on RESET=1 at a CLK edge, set the state to IDLE and set f_q=0, EVT=0, COUNT=0, LAST_S=0, GAP=0, OVF=0, gap_cnt=0 and FIFO pointers to 0, giving EMPTY=1, FULL=0, DOUT=0.
REQ-022 SHALL have RESET take priority over CLR, events and RD.
REQ-023 SHALL handle reset mid-operation cleanly: an F already high when RESET falls produces an event on the first post-reset cycle, because f_q=0.
REQ-024 SHALL have CLR reset the same registers as RESET, except f_q, which keeps updating.

Configuration
REQ-025 SHALL, with EVT_FIFO_EN defined, push LAST_S's new value into a 4-entry FIFO on each event and pop it on RD when not EMPTY.
REQ-026 SHALL, when the FIFO is full, drop the pushed event and leave the FIFO contents unchanged.
REQ-027 SHALL, on a simultaneous push and pop, perform both, including when FULL.
REQ-028 SHALL present DOUT as the head entry (first-word fall-through), with DOUT=0 when EMPTY.
REQ-029 SHALL, with EVT_FIFO_EN undefined, keep the FIFO ports present, tie DOUT=0, EMPTY=1 and FULL=0, ignore RD, and synthesise no FIFO storage.

Structure
REQ-030 SHALL place the widths (CNT_W=8, S_W=3), FIFO_DEPTH=4 and the state type {IDLE, TRACK} in the shared package f_event_pkg.
REQ-031 SHALL implement the FIFO as the sub-module evt_fifo, instantiated only under EVT_FIFO_EN.

Verification
REQ-032 SHALL cover this scenario: reset, then F pulses high 2 cycles starting at cycle 3 with S=3'b011 -> one EVT at cycle 4, COUNT=1, LAST_S=3, GAP=0.
REQ-033 SHALL cover this scenario: rising edges of F 10 cycles apart -> GAP=10 after the second event, and COUNT=2.
REQ-034 SHALL cover this scenario: 256 events -> COUNT=255, OVF=1; then CLR -> COUNT=0, OVF=0, state IDLE.
REQ-035 SHALL cover this scenario: F held high for 20 cycles -> exactly one EVT.
REQ-036 SHALL cover this scenario: with EVT_FIFO_EN, 5 events with S=1..5 and no RD -> FULL=1; four RD pops give DOUT 1,2,3,4, then EMPTY=1.
REQ-037 SHALL cover this scenario: RESET asserted in the same cycle as an event edge -> EVT=0 and COUNT=0 on the next cycle.
